// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
package display_pkg;

    localparam int BRIGHT_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // abcdefg, active low
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // Largest value representable in the given number of decimal digits.
    function automatic int max_value(int digits);
        int m = 1;
        for (int i = 0; i < digits; i++) m = m * 10;
        return m - 1;
    endfunction

    // Decimal digits needed for any unsigned value of the given bit width.
    function automatic int bcd_digits(int width);
        return (width * 30103) / 100000 + 1;
    endfunction

    function automatic logic [6:0] seg_decode(logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/display_controller_mux_if.sv
// Value handshake between the datapath source and the display controller.
interface display_controller_mux_if #(
    parameter int VALUE_W = 14
);
    logic [VALUE_W-1:0] value;
    logic               value_valid;
    logic               value_ready;

    modport master (output value, output value_valid, input value_ready);
    modport slave  (input value, input value_valid, output value_ready);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter, one bit per clock.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow
);
    // Always keep at least one digit above the displayed ones so overflow has somewhere to land.
    localparam int INT_DIGITS = (bcd_digits(VALUE_W) > NUM_DIGITS) ? bcd_digits(VALUE_W) : NUM_DIGITS + 1;
    localparam int BCD_W      = 4 * INT_DIGITS;
    localparam int CNT_W      = $clog2(VALUE_W);

    logic [VALUE_W-1:0] bin_sh;
    logic [BCD_W-1:0]   acc, acc_adj, acc_nxt;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < INT_DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
        acc_nxt = BCD_W'({acc_adj, bin_sh[VALUE_W-1]});
    end

    // bcd/overflow are the result of the step being taken now, valid while done is high.
    assign done     = busy && (cnt == CNT_W'(VALUE_W-1));
    assign bcd      = acc_nxt[4*NUM_DIGITS-1:0];
    assign overflow = |acc_nxt[BCD_W-1:4*NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            bin_sh <= '0;
        end else if (!busy) begin
            if (start) begin
                busy   <= 1'b1;
                cnt    <= '0;
                acc    <= '0;
                bin_sh <= bin;
            end
        end else begin
            acc    <= acc_nxt;
            bin_sh <= bin_sh << 1;
            cnt    <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/display_controller_mux.sv
// Multiplexed N-digit 7-segment driver: value handshake, BCD conversion, digit scan,
// leading-zero blanking, PWM brightness, blink and overflow dashes.
module display_controller_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    display_controller_mux_if.slave value_bus,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    input  logic                    blink_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic                    start, busy, done, conv_ovf;
    logic [4*NUM_DIGITS-1:0] conv_bcd;

    logic [NUM_DIGITS-1:0][3:0] disp_bcd;
    logic                       disp_ovf;

    logic [REF_W-1:0]    refresh_cnt;
    logic [IDX_W-1:0]    scan_idx;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_on;
    logic                wrap, round_end;

    logic [NUM_DIGITS-1:0] blank;
    logic [6:0]            seg_nxt;
    logic                  lit;

    assign start                 = value_bus.value_valid && !busy;
    assign value_bus.value_ready = !busy;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (value_bus.value),
        .busy     (busy),
        .done     (done),
        .bcd      (conv_bcd),
        .overflow (conv_ovf)
    );

    // All digits and the overflow flag land together, so no partial result is ever shown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else if (done) begin
            disp_bcd <= conv_bcd;
            disp_ovf <= conv_ovf;
        end
    end

    assign wrap      = (refresh_cnt == REF_W'(REFRESH_DIV-1));
    assign round_end = wrap && (scan_idx == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= IDX_W'(NUM_DIGITS-1);
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
        end else begin
            refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
            pwm_cnt     <= pwm_cnt + 1'b1;
            if (wrap) scan_idx <= (scan_idx == '0) ? IDX_W'(NUM_DIGITS-1) : scan_idx - 1'b1;
            if (round_end) blink_cnt <= (blink_cnt == BLK_W'(BLINK_DIV-1)) ? '0 : blink_cnt + 1'b1;
            if (!blink_en)
                blink_on <= 1'b1;
            else if (round_end && blink_cnt == BLK_W'(BLINK_DIV-1))
                blink_on <= ~blink_on;
        end
    end

    // A digit blanks when it and everything above it is zero; digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS-1; i >= 0; i--) begin
            upper_zero = upper_zero && (disp_bcd[i] == 4'd0);
            blank[i]   = lz_blank && !disp_ovf && upper_zero && (i != 0);
        end
    end

    always_comb begin
        if (disp_ovf)
            seg_nxt = SEG_DASH;
        else if (blank[scan_idx])
            seg_nxt = SEG_BLANK;
        else
            seg_nxt = seg_decode(disp_bcd[scan_idx]);
        lit = ((brightness == '1) || (pwm_cnt < brightness)) && !(blink_en && !blink_on);
    end

    // Pins are all registered from the same scan index, so digit and pattern never skew.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            segments  <= SEG_BLANK;
            dp        <= 1'b1;
            digit_sel <= '1;
        end else begin
            segments  <= seg_nxt;
            dp        <= ~dp_mask[scan_idx];
            digit_sel <= lit ? ~(NUM_DIGITS'(1) << scan_idx) : '1;
        end
    end

endmodule

// File: tb/tb_display_controller_mux.sv
// Randomized bench for display_controller_mux, checked every cycle against a value-level model.
module tb_display_controller_mux;
    import display_pkg::*;

    localparam int N     = 4;
    localparam int VW    = 14;
    localparam int RD    = 4;
    localparam int BD    = 2;
    localparam int ROUND = RD * N;

    localparam logic [6:0] SEG_REF [10] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] dp_mask;
    logic         lz_blank;
    logic         blink_en;
    logic [3:0]   brightness;
    logic [6:0]   segments;
    logic         dp;
    logic [N-1:0] digit_sel;

    int n_chk  = 0;
    int n_pass = 0;

    // model state: edges since reset release, shown value, pending conversion, blink phase
    int m_k, m_disp, m_pend, m_done_k;
    bit m_ready, m_phase;

    display_controller_mux_if #(.VALUE_W(VW)) vbus ();

    display_controller_mux #(
        .NUM_DIGITS  (N),
        .VALUE_W     (VW),
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_bus  (vbus),
        .dp_mask    (dp_mask),
        .lz_blank   (lz_blank),
        .blink_en   (blink_en),
        .brightness (brightness),
        .segments   (segments),
        .dp         (dp),
        .digit_sel  (digit_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    function automatic int pow10(int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    // One clock: predict pins from the model state before the edge, then advance the model.
    task automatic step();
        int         idx, pwm, dig;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [N-1:0] e_sel;
        bit         on;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_k = 0; m_disp = 0; m_ready = 1'b1; m_phase = 1'b1;
            e_seg = 7'h7F; e_dp = 1'b1; e_sel = '1;
        end else begin
            idx = N - 1 - ((m_k / RD) % N);
            pwm = m_k % 16;
            dig = (m_disp / pow10(idx)) % 10;
            if (m_disp > max_value(N))
                e_seg = 7'h7E;
            else if (lz_blank && idx > 0 && m_disp < pow10(idx))
                e_seg = 7'h7F;
            else
                e_seg = SEG_REF[dig];
            e_dp  = ~dp_mask[idx];
            on    = (brightness == 4'hF || pwm < int'(brightness)) && !(blink_en && !m_phase);
            e_sel = on ? ~(N'(1) << idx) : '1;

            m_k++;
            if (vbus.value_valid && m_ready) begin
                m_ready  = 1'b0;
                m_pend   = int'(vbus.value);
                m_done_k = m_k + VW;
            end else if (!m_ready && m_k == m_done_k) begin
                m_disp  = m_pend;
                m_ready = 1'b1;
            end
            if (!blink_en)
                m_phase = 1'b1;
            else if (m_k % ROUND == 0 && (m_k / ROUND) % BD == 0)
                m_phase = ~m_phase;
        end
        chk("segments", int'(segments), int'(e_seg));
        chk("dp", int'(dp), int'(e_dp));
        chk("digit_sel", int'(digit_sel), int'(e_sel));
        chk("value_ready", int'(vbus.value_ready), int'(m_ready));
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic send(int v);
        bit took = 1'b0;
        vbus.value       = VW'(v);
        vbus.value_valid = 1'b1;
        for (int i = 0; i < 40 && !took; i++) begin
            took = m_ready;
            step();
        end
        vbus.value_valid = 1'b0;
        chk("accept", int'(took), 1);
    endtask

    initial begin
        int lo, cnt;
        rst_n = 1'b0; vbus.value = '0; vbus.value_valid = 1'b0;
        dp_mask = '0; lz_blank = 1'b0; blink_en = 1'b0; brightness = 4'hF;
        idle(3);
        rst_n = 1'b1;
        idle(32);

        send(1234);
        lo = 0;
        for (int i = 0; i < 40 && vbus.value_ready == 1'b0; i++) begin
            step();
            lo++;
        end
        chk("ready_low", lo, 14);
        idle(20);

        lz_blank = 1'b1;
        send(7);    idle(30);
        send(0);    idle(30);
        dp_mask = 4'b0010;
        idle(20);
        lz_blank = 1'b0; dp_mask = '0;

        send(12000); idle(30);
        send(9999);  idle(30);

        brightness = 4'd4;
        cnt = 0;
        repeat (16) begin
            step();
            if (digit_sel != '1) cnt++;
        end
        chk("pwm_on_cycles", cnt, 4);
        brightness = 4'd0;
        cnt = 0;
        repeat (20) begin
            step();
            if (digit_sel != '1) cnt++;
        end
        chk("dark_cycles", cnt, 0);
        brightness = 4'hF;

        blink_en = 1'b1;
        idle(130);
        blink_en = 1'b0;
        idle(10);

        send(500);
        idle(5);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("rst_ready", int'(vbus.value_ready), 1);
        chk("rst_seg", int'(segments), 'h01);
        idle(20);

        for (int r = 0; r < 40; r++) begin
            lz_blank   = 1'($urandom_range(0, 1));
            dp_mask    = N'($urandom);
            brightness = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            blink_en   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 1) send(int'($urandom_range(0, 16383)));
            else send(int'($urandom_range(0, 120)));
            idle(int'($urandom_range(14, 30)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
